pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised elastic pipeline-stage register, the generalised successor to the fixed inter-stage registers between MEM and WB (and any other stage pair). It carries an opaque DATA_W-bit payload bundle (control, ALU result, load data, write address, PC+8, etc., packed by the instantiating stage) with valid/ready handshaking, synchronous flush, and an optional two-entry skid buffer. The skid buffer keeps upstream ready off the downstream combinational path. Downstream stall back-pressures cleanly without dropping or duplicating beats.

## Interface
Parameters:
- DATA_W, 137, payload width in bits; legal range ≥1.
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single-entry register with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- flush  in  1  synchronous kill of all held beats (branch/exception squash).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload of the presented beat.
- occupancy  out  2  number of held beats (0..2; max 1 when SKID=0).

## Operation
- Storage: main entry (main_valid, main_data); when SKID=1 also skid entry (skid_valid, skid_data).
- out_valid = main_valid; out_data = main_data. Data regs load only when an entry is written; otherwise they hold their value, including after drain.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- SKID=1:
  - in_ready = ~skid_valid & ~flush.
  - Main empty, accept: in_data → main.
  - Main full, drain, skid empty, accept: in_data → main (pass-through replace).
  - Main full, no drain, accept: in_data → skid; in_ready drops next cycle.
  - Drain with skid full: skid → main, skid empties; no accept possible that cycle (in_ready=0).
  - Order strictly FIFO; no beat lost or duplicated.
- SKID=0:
  - in_ready = (~main_valid | out_ready) & ~flush.
  - Accept → main; drain without accept → main_valid clears.
- Flush (both modes): next edge clears main_valid and skid_valid; in_ready=0 during flush, so no beat is accepted. A beat draining in the flush cycle still counts as delivered downstream. Data regs are not cleared.
- occupancy = main_valid + skid_valid (registered-state derived, no combinational input dependence).

## Timing
- Reset (async assert, sync-safe deassert by system): main_valid=0, skid_valid=0, main_data=0, skid_data=0. Hence out_valid=0, out_data=0, occupancy=0; in_ready=1 (if flush=0).
- Latency: accepted beat visible on out_valid/out_data the cycle after acceptance (1 cycle). Skid path adds no latency beyond waiting for downstream.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously.
- SKID=1: in_ready depends only on state and flush. It tolerates upstream holding in_valid for one cycle after stall onset.
- Simultaneous accept + drain with main full, skid empty: occupancy stays 1.
- Simultaneous flush + in_valid: beat discarded upstream-side (not accepted, upstream must hold or drop per its own flush).
- Reset mid-transfer: all held beats lost; no partial beat emitted.
- Stable hold: while out_valid=1 and out_ready=0, out_data must not change.

## Test plan
- Reset: assert reset mid-stream with occupancy=2 → same cycle out_valid=0, occupancy=0, out_data=0; after release in_ready=1.
- Streaming: SKID=1, out_ready=1, send 0x01..0x10 back-to-back → out_data 0x01..0x10 each one cycle later, in_ready never drops, occupancy stays 1.
- Stall: hold out_ready=0 while sending 0xA, 0xB, 0xC → 0xA held in main, 0xB in skid, in_ready=0, 0xC held upstream. Release → outputs 0xA, 0xB, 0xC in order with no gap.
- Flush: occupancy=2 (0x5, 0x6) and flush=1 with in_valid=1 (0x7) → next cycle occupancy=0, out_valid=0; 0x7 not accepted (in_ready=0 during flush).
- SKID=0: out_ready toggles 1,0,1,0 with in_valid=1 constant, payload incrementing → in_ready follows (~main_valid | out_ready); every accepted value emitted exactly once, occupancy ≤1.
- Random: random in_valid/out_ready/flush over 10k cycles, DATA_W=137 → scoreboard shows in-order, no loss/duplication except flushed beats; out_data stable while stalled.

Source files
------------

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_skid_stage                                                 |
// | Purpose  : Elastic pipeline-stage register for an opaque payload bundle,   |
// |            with valid/ready handshaking, synchronous flush and an optional |
// |            two-entry skid buffer that registers in_ready.                  |
// | Ports    : clk, reset      - clock / async active-high reset               |
// |            flush           - synchronous kill of all held beats            |
// |            in_valid/in_ready/in_data    - upstream handshake + payload     |
// |            out_valid/out_ready/out_data - downstream handshake + payload   |
// |            occupancy       - number of beats currently held (0..2)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_skid_stage #(
  parameter int DATA_W = 137,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_load_main_in;   // in_data written into main
  logic w_load_main_skid; // skid entry promoted into main
  logic w_load_skid;      // in_data parked in skid

  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on registered state and flush, so it never sits
      // on the downstream combinational path.
      assign in_ready         = ~r_skid_valid & ~flush;
      // Main is written from the input when empty, or when it drains with
      // nothing waiting in skid (pass-through replace).
      assign w_load_main_in   = w_accept & (~r_main_valid | (w_drain & ~r_skid_valid));
      // Flush suppresses the promotion so no entry is written that cycle.
      assign w_load_main_skid = w_drain & r_skid_valid & ~flush;
      assign w_load_skid      = w_accept & r_main_valid & ~w_drain;
    end else begin : g_noskid
      assign in_ready         = (~r_main_valid | out_ready) & ~flush;
      assign w_load_main_in   = w_accept;
      assign w_load_main_skid = 1'b0;
      assign w_load_skid      = 1'b0;
    end
  endgenerate

  // Valid flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_load_main_in || w_load_main_skid) begin
        r_main_valid <= 1'b1;
      end else if (w_drain) begin
        r_main_valid <= 1'b0;
      end

      if (w_load_skid) begin
        r_skid_valid <= 1'b1;
      end else if (w_load_main_skid) begin
        r_skid_valid <= 1'b0;
      end
    end
  end

  // Payload registers load only when their entry is written, so out_data
  // holds steady while stalled and keeps its last value after draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end

      if (w_load_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_skid_stage                                              |
// | Purpose  : Self-checking bench for pipe_skid_stage. Drives one skid-mode   |
// |            and one register-mode instance with shared stimulus; a queue    |
// |            per instance holds the beats it should currently contain.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_skid_stage;

  localparam int DW = 137;
  typedef logic [DW-1:0] data_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  data_t      in_data;

  logic       in_ready0, out_valid0, in_ready1, out_valid1;
  data_t      out_data0, out_data1;
  logic [1:0] occ0, occ1;

  int n_checks = 0;
  int n_fail   = 0;

  data_t q0[$];
  data_t q1[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .SKID(1)) u_dut_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .occupancy (occ0)
  );

  pipe_skid_stage #(.DATA_W(DW), .SKID(0)) u_dut_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occ1)
  );

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Compare one instance against its queue, then advance the queue by the
  // handshakes that will happen at the coming edge.
  task automatic model_step(input int k);
    data_t      q[$];
    logic       rdy_o, val_o, exp_rdy, acc, drn;
    data_t      dat_o;
    logic [1:0] occ_o;
    string      p;
    if (k == 0) begin
      q = q0; rdy_o = in_ready0; val_o = out_valid0; dat_o = out_data0; occ_o = occ0;
      p = "skid";
      exp_rdy = (q.size() < 2) && !flush;
    end else begin
      q = q1; rdy_o = in_ready1; val_o = out_valid1; dat_o = out_data1; occ_o = occ1;
      p = "reg";
      exp_rdy = ((q.size() == 0) || out_ready) && !flush;
    end
    check({p, ".out_valid"}, DW'(val_o), DW'(q.size() > 0));
    if (q.size() > 0) check({p, ".out_data"}, dat_o, q[0]);
    check({p, ".occupancy"}, DW'(occ_o), DW'(q.size()));
    check({p, ".in_ready"}, DW'(rdy_o), DW'(exp_rdy));
    acc = in_valid & exp_rdy;
    drn = (q.size() > 0) & out_ready;
    if (drn) void'(q.pop_front());
    if (flush) q.delete();      // a beat draining this cycle is already gone
    if (acc) q.push_back(in_data);
    if (k == 0) q0 = q; else q1 = q;
  endtask

  // Drive one cycle's inputs just after a rising edge, check mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cycle(input logic iv, input data_t d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #2;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [159:0] r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset.out_valid", DW'(out_valid0), '0);
    check("reset.occupancy", DW'(occ0), '0);
    check("reset.out_data", out_data0, '0);
    check("reset.in_ready", DW'(in_ready0), DW'(1'b1));

    // Fill the skid instance to two beats, then reset asynchronously.
    cycle(1'b1, DW'('h11), 1'b0, 1'b0);
    cycle(1'b1, DW'('h22), 1'b0, 1'b0);
    check("prereset.occupancy", DW'(occ0), DW'(2));
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("midreset.out_valid", DW'(out_valid0), '0);
    check("midreset.occupancy", DW'(occ0), '0);
    check("midreset.out_data", out_data0, '0);
    check("midreset.reg_occupancy", DW'(occ1), '0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("postreset.in_ready", DW'(in_ready0), DW'(1'b1));
    check("postreset.reg_in_ready", DW'(in_ready1), DW'(1'b1));

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall with three offers, then release
    cycle(1'b1, DW'('hA), 1'b0, 1'b0);
    cycle(1'b1, DW'('hB), 1'b0, 1'b0);
    cycle(1'b1, DW'('hC), 1'b0, 1'b0);
    cycle(1'b1, DW'('hC), 1'b0, 1'b0);
    cycle(1'b1, DW'('hC), 1'b1, 1'b0);
    cycle(1'b1, DW'('hC), 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with two held beats and a concurrent offer
    cycle(1'b1, DW'('h5), 1'b0, 1'b0);
    cycle(1'b1, DW'('h6), 1'b0, 1'b0);
    cycle(1'b1, DW'('h7), 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Toggling downstream ready with constant upstream valid
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'('h40 + i), (i % 2) == 0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cycle($urandom_range(0, 1) == 1, r[DW-1:0], $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    end
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
